serial_paralelo: RTL and testbench

Receive-side deserializer that sits directly downstream of the parallel-to-serial stage. It takes the 1-bit serial stream and finds byte alignment on the 0xBC idle/COM symbol. It declares the link active after four consecutive aligned 0xBC bytes, then presents every non-0xBC byte as an 8-bit word with a one-cycle valid strobe. The block runs entirely in the `clk_32f` domain.

---
 rtl/serial_paralelo_if.sv | 12 +
 rtl/serial_paralelo.sv | 109 ++++++++++
 tb/tb_serial_paralelo.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_paralelo_if.sv
// Serial receive link bundle: 1-bit stream in, aligned bytes and link status out.
interface serial_paralelo_if;
    localparam int unsigned BYTE_W = 8;

    logic              data_in;
    logic [BYTE_W-1:0] data_out;
    logic              valid_out;
    logic              active;

    modport master (output data_in, input data_out, valid_out, active);
    modport slave  (input data_in, output data_out, valid_out, active);
endinterface

// File: rtl/serial_paralelo.sv
// Receive deserializer: aligns on the COM symbol, locks after COM_LOCK aligned COMs,
// then strobes out every non-COM byte.
module serial_paralelo #(
    parameter logic [7:0]  COM      = 8'hBC,
    parameter int unsigned COM_LOCK = 4
) (
    input  logic             clk_32f,
    input  logic             reset,
    serial_paralelo_if.slave bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 3;

    typedef enum logic [1:0] {
        SEARCH,
        LOCK,
        ACTIVE
    } state_t;

    state_t             state_q, state_d;
    logic [BYTE_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   com_cnt_q, com_cnt_d;
    logic [BYTE_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               active_q, active_d;
    logic [BYTE_W-1:0]  w;
    logic               boundary;

    // State register and registered outputs
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            state_q   <= SEARCH;
            sr_q      <= '0;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
        end
    end

    // Next-state: alignment search, lock confirmation, byte delivery
    always_comb begin
        w         = {sr_q[BYTE_W-2:0], bus.data_in};
        boundary  = (bit_cnt_q == CNT_W'(7));
        state_d   = state_q;
        sr_d      = w;
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
        com_cnt_d = com_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        active_d  = active_q;

        unique case (state_q)
            SEARCH: begin
                // Any bit offset is accepted here; a false match fails the next boundary.
                if (w == COM) begin
                    bit_cnt_d = '0;
                    com_cnt_d = CNT_W'(1);
                    if (COM_LOCK <= 1) begin
                        state_d  = ACTIVE;
                        active_d = 1'b1;
                    end else begin
                        state_d = LOCK;
                    end
                end
            end
            LOCK: begin
                if (boundary) begin
                    if (w == COM) begin
                        if ((com_cnt_q + CNT_W'(1)) >= CNT_W'(COM_LOCK)) begin
                            com_cnt_d = CNT_W'(COM_LOCK);
                            state_d   = ACTIVE;
                            active_d  = 1'b1;
                        end else begin
                            com_cnt_d = com_cnt_q + CNT_W'(1);
                        end
                    end else begin
                        com_cnt_d = '0;
                        state_d   = SEARCH;
                    end
                end
            end
            ACTIVE: begin
                // Alignment is frozen once active; COM bytes are idles.
                if (boundary && (w != COM)) begin
                    data_d  = w;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
    assign bus.active    = active_q;
endmodule

// File: tb/tb_serial_paralelo.sv
// Self-checking bench for serial_paralelo: directed test-plan steps plus randomized
// streams, every cycle compared against a bit-history reference model.
module tb_serial_paralelo;
    localparam logic [7:0] COM      = 8'hBC;
    localparam int         COM_LOCK = 4;

    logic clk_32f = 1'b0;
    logic reset   = 1'b1;

    serial_paralelo_if bus ();

    serial_paralelo #(
        .COM      (COM),
        .COM_LOCK (COM_LOCK)
    ) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_32f = ~clk_32f;

    int total = 0;
    int bad   = 0;

    // Reference model: history of received bits, alignment cycle and COM run length
    logic       hist[$];
    int         m_t;
    int         m_align;
    int         m_ncom;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_active;

    // Observation log since last reset
    int         bitn;
    int         act_at;
    logic [7:0] st_data[$];
    int         st_at[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] window();
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            int idx;
            idx = hist.size() - 1 - i;
            if (idx >= 0) r[i] = hist[idx];
        end
        return r;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_t      = 0;
        m_align  = -1;
        m_ncom   = 0;
        m_data   = 8'h00;
        m_valid  = 1'b0;
        m_active = 1'b0;
    endtask

    task automatic model_step(input logic b);
        logic [7:0] w;
        hist.push_back(b);
        if (hist.size() > 8) void'(hist.pop_front());
        w = window();
        m_valid = 1'b0;
        if (m_align < 0) begin
            if (w == COM) begin
                m_align = m_t;
                m_ncom  = 1;
                if (m_ncom >= COM_LOCK) m_active = 1'b1;
            end
        end else if (((m_t - m_align) % 8) == 0) begin
            if (!m_active) begin
                if (w == COM) begin
                    m_ncom++;
                    if (m_ncom >= COM_LOCK) m_active = 1'b1;
                end else begin
                    m_align = -1;
                    m_ncom  = 0;
                end
            end else if (w != COM) begin
                m_data  = w;
                m_valid = 1'b1;
            end
        end
        m_t++;
    endtask

    task automatic observe();
        check("data_out", bus.data_out, m_data);
        check("valid_out", bus.valid_out, m_valid);
        check("active", bus.active, m_active);
        if (bus.active === 1'b1 && act_at == 0) act_at = bitn;
        if (bus.valid_out === 1'b1) begin
            st_data.push_back(bus.data_out);
            st_at.push_back(bitn);
        end
    endtask

    task automatic do_reset(input int n, input logic b0);
        logic b;
        b = b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_32f);
            reset       = 1'b1;
            bus.data_in = b;
            b = ~b;
            @(posedge clk_32f);
            model_reset();
            bitn   = 0;
            act_at = 0;
            st_data.delete();
            st_at.delete();
            #1;
            observe();
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        reset       = 1'b0;
        bus.data_in = b;
        @(posedge clk_32f);
        model_step(b);
        bitn++;
        #1;
        observe();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    initial begin
        bus.data_in = 1'b0;
        model_reset();
        bitn   = 0;
        act_at = 0;

        // Reset held two cycles with toggling data
        do_reset(2, 1'b1);
        check("rst data_out", bus.data_out, 8'h00);
        check("rst valid_out", bus.valid_out, 1'b0);
        check("rst active", bus.active, 1'b0);

        // Aligned lock, then two data bytes
        for (int i = 0; i < 4; i++) send_byte(COM);
        check("t2 act_at", act_at, 32);
        send_byte(8'hA5);
        send_byte(8'h3C);
        check("t2 n_strobe", st_data.size(), 2);
        check("t2 s0 data", st_data[0], 8'hA5);
        check("t2 s0 at", st_at[0], 40);
        check("t2 s1 data", st_data[1], 8'h3C);
        check("t2 s1 at", st_at[1], 48);

        // Three junk bits offset the stream
        do_reset(2, 1'b0);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int i = 0; i < 4; i++) send_byte(COM);
        send_byte(8'h5A);
        check("t3 act_at", act_at, 35);
        check("t3 n_strobe", st_data.size(), 1);
        check("t3 s0 data", st_data[0], 8'h5A);
        check("t3 s0 at", st_at[0], 43);

        // Short COM run is rejected, second run locks
        do_reset(1, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(COM);
        send_byte(8'h11);
        check("t4 inactive", bus.active, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(COM);
        send_byte(8'h22);
        check("t4 act_at", act_at, 64);
        check("t4 n_strobe", st_data.size(), 1);
        check("t4 s0 data", st_data[0], 8'h22);

        // Idles between data bytes in ACTIVE
        send_byte(8'h77);
        send_byte(COM);
        check("t5 hold", bus.data_out, 8'h77);
        send_byte(COM);
        send_byte(8'h88);
        check("t5 n_strobe", st_data.size(), 3);
        check("t5 s1 data", st_data[1], 8'h77);
        check("t5 s2 data", st_data[2], 8'h88);
        check("t5 spacing", st_at[2] - st_at[1], 24);

        // Reset on a boundary cycle suppresses the strobe; relock needs 4 new COMs
        for (int i = 7; i >= 1; i--) send_bit(1'(8'h99 >> i));
        do_reset(1, 1'b1);
        check("t6 valid", bus.valid_out, 1'b0);
        check("t6 data", bus.data_out, 8'h00);
        check("t6 active", bus.active, 1'b0);
        check("t6 n_strobe", st_data.size(), 0);
        for (int i = 0; i < 3; i++) send_byte(COM);
        check("t6 not relocked", bus.active, 1'b0);
        send_byte(COM);
        check("t6 relock", bus.active, 1'b1);
        check("t6 act_at", act_at, 32);

        // Random offset, lock, random payload with idles
        do_reset(2, 1'b0);
        begin
            int n;
            n = $urandom_range(0, 7);
            for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 4; i++) send_byte(COM);
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) send_byte(COM);
            else send_byte(8'($urandom));
        end

        // COM-heavy stream with bit slips and occasional resets
        do_reset(1, 1'b1);
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) == 0) send_bit(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 49) == 0) do_reset(1, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) < 7) send_byte(COM);
            else send_byte(8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
